risc_mem_arbiter: RTL

- Arbitrates one single-port synchronous data/instruction RAM between three requesters:
  - the control unit's instruction fetch (IF),
  - its load/store path (DM),
  - a debug/program loader port (DBG).
- Sits between the RISC control unit / datapath and the memory macro, so program load and execution share one RAM.
- Sequences every access as a fixed 3-state transaction and returns read data with a one-cycle ack pulse.
- Starvation guard keeps fetch from being locked out by back-to-back data traffic.

---
 rtl/risc_mem_pkg.sv | 25 ++
 rtl/risc_mem_prio_pick.sv | 28 ++
 rtl/risc_mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/risc_mem_pkg.sv
`default_nettype none
// ============================================================================
// risc_mem_pkg - shared types and default widths for the RISC RAM arbiter
// Rev 1.0
// ============================================================================
package risc_mem_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_DBG  = 2'd3
  } requester_t;

endpackage
`default_nettype wire

// File: rtl/risc_mem_prio_pick.sv
`default_nettype none
// ============================================================================
// risc_mem_prio_pick - fixed DBG > DM > IF priority with IF promotion on starve
// Rev 1.0
// ============================================================================
module risc_mem_prio_pick
  import risc_mem_pkg::*;
(
  input  logic       if_req_i,
  input  logic       dm_req_i,
  input  logic       dbg_req_i,
  input  logic       if_starved_i,
  output requester_t pick_o
);

  always_comb begin
    pick_o = REQ_NONE;
    if (dbg_req_i) begin
      pick_o = REQ_DBG;
    end else if (dm_req_i && !(if_req_i && if_starved_i)) begin
      pick_o = REQ_DM;
    end else if (if_req_i) begin
      pick_o = REQ_IF;
    end
  end

endmodule
`default_nettype wire

// File: rtl/risc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// risc_mem_arbiter - shares one synchronous RAM between fetch, data and debug
// Rev 1.0
// ============================================================================
module risc_mem_arbiter
  import risc_mem_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  arb_state_t    state_q, state_d;
  requester_t    owner_q, owner_d;
  requester_t    w_pick;
  logic          w_if_starved;
  logic [3:0]    starve_q, starve_d;
  logic          store_q, store_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic          dbg_ack_q, dbg_ack_d;

  assign w_if_starved = (starve_q == c_starve_max);

  risc_mem_prio_pick u_prio_pick (
    .if_req_i     (if_req),
    .dm_req_i     (dm_req),
    .dbg_req_i    (dbg_req),
    .if_starved_i (w_if_starved),
    .pick_o       (w_pick)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    store_d     = store_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    dbg_ack_d   = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (w_pick != REQ_NONE) begin
          state_d  = ARB_ISSUE;
          owner_d  = w_pick;
          mem_en_d = 1'b1;
          if (!if_req || w_pick == REQ_IF) begin
            starve_d = '0;
          end else if (starve_q != c_starve_max) begin
            starve_d = starve_q + 4'd1;
          end
          case (w_pick)
            REQ_IF: begin
              mem_addr_d = if_addr;
              store_d    = 1'b0;
            end
            REQ_DM: begin
              mem_addr_d  = dm_addr;
              mem_we_d    = dm_we;
              mem_wdata_d = dm_wdata;
              store_d     = dm_we;
            end
            REQ_DBG: begin
              mem_addr_d  = dbg_addr;
              mem_we_d    = dbg_we;
              mem_wdata_d = dbg_wdata;
              store_d     = dbg_we;
            end
            default: ;
          endcase
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        // RAM output is valid here; stores keep the last read value visible.
        state_d = ARB_IDLE;
        owner_d = REQ_NONE;
        if (!store_q) begin
          rdata_d = mem_rdata;
        end
        case (owner_q)
          REQ_IF:  if_ack_d  = 1'b1;
          REQ_DM:  dm_ack_d  = 1'b1;
          REQ_DBG: dbg_ack_d = 1'b1;
          default: ;
        endcase
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= REQ_NONE;
      starve_q    <= '0;
      store_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      dbg_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      store_q     <= store_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      dbg_ack_q   <= dbg_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule
`default_nettype wire
